// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
// Pure declarations: no logic, no latency, no flow control.
package mips_bus_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUS, ARB_RESP} arb_state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   localparam logic [3:0]  BE_WORD      = 4'b1111;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and load/store; 1 cycle to drive the bus,
// read data READ_LATENCY+1 cycles after acceptance; m_waitrequest stalls the granted master, the loser waits.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter bit FIRST_DATA   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   output logic        i_readdatavalid,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic        d_readdatavalid,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata
);

   localparam logic [1:0] RESP_CNT    = 2'(READ_LATENCY - 1);
   localparam grant_t     FIRST_GRANT = FIRST_DATA ? GRANT_D : GRANT_I;

   arb_state_t  state, state_nxt;
   grant_t      grant, grant_nxt;
   grant_t      rr_ptr, rr_ptr_nxt;
   logic [1:0]  count, count_nxt;
   logic [31:0] cmd_address;
   logic [31:0] cmd_writedata;
   logic [3:0]  cmd_byteenable;
   logic        cmd_read;
   logic        cmd_write;
   logic        i_req;
   logic        d_req;
   logic        accept;
   logic        load_cmd;
   logic        capture;

   assign i_req  = i_read;
   assign d_req  = d_read | d_write;
   assign accept = (state == ARB_BUS) && !m_waitrequest;

   assign i_waitrequest = !(accept && (grant == GRANT_I));
   assign d_waitrequest = !(accept && (grant == GRANT_D));

   // The bus only ever sees the latched command, so master-side wiggles cannot leak through.
   assign m_address    = cmd_address;
   assign m_read       = cmd_read;
   assign m_write      = cmd_write;
   assign m_writedata  = cmd_writedata;
   assign m_byteenable = cmd_byteenable;

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      count_nxt  = count;
      load_cmd   = 1'b0;
      capture    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (i_req || d_req) begin
               load_cmd  = 1'b1;
               state_nxt = ARB_BUS;
               if (i_req && d_req) begin
                  grant_nxt  = rr_ptr;
                  rr_ptr_nxt = (rr_ptr == GRANT_I) ? GRANT_D : GRANT_I;
               end else begin
                  grant_nxt = d_req ? GRANT_D : GRANT_I;
               end
            end
         end
         ARB_BUS: begin
            if (accept) begin
               if (cmd_read) begin
                  state_nxt = ARB_RESP;
                  count_nxt = RESP_CNT;
               end else begin
                  state_nxt = ARB_IDLE;
               end
            end
         end
         ARB_RESP: begin
            if (count == 2'd0) begin
               capture   = 1'b1;
               state_nxt = ARB_IDLE;
            end else begin
               count_nxt = count - 2'd1;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ARB_IDLE;
         grant  <= GRANT_I;
         rr_ptr <= FIRST_GRANT;
         count  <= 2'd0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
         count  <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_address    <= '0;
         cmd_writedata  <= '0;
         cmd_byteenable <= '0;
         cmd_read       <= 1'b0;
         cmd_write      <= 1'b0;
      end else if (load_cmd) begin
         if (grant_nxt == GRANT_D) begin
            // A simultaneous read and write from the data side is treated as a write.
            cmd_address    <= d_address;
            cmd_read       <= d_read & ~d_write;
            cmd_write      <= d_write;
            cmd_writedata  <= d_writedata;
            cmd_byteenable <= d_write ? d_byteenable : BE_WORD;
         end else begin
            cmd_address    <= i_address;
            cmd_read       <= 1'b1;
            cmd_write      <= 1'b0;
            cmd_writedata  <= '0;
            cmd_byteenable <= BE_WORD;
         end
      end else if (accept) begin
         cmd_read  <= 1'b0;
         cmd_write <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         i_readdata      <= '0;
         d_readdata      <= '0;
         i_readdatavalid <= 1'b0;
         d_readdatavalid <= 1'b0;
      end else begin
         i_readdatavalid <= capture && (grant == GRANT_I);
         d_readdatavalid <= capture && (grant == GRANT_D);
         if (capture && (grant == GRANT_I)) begin
            i_readdata <= m_readdata;
         end
         if (capture && (grant == GRANT_D)) begin
            d_readdata <= m_readdata;
         end
      end
   end

endmodule
